// File: rtl/l1_i_pkg.sv
// rtl/l1_i_pkg.sv - shared types, defaults and replacement helpers for the N-way L1 instruction cache
package l1_i_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_e;

    localparam int DEF_WAYS      = 4;
    localparam int DEF_INUM      = 5;
    localparam int DEF_LINE_BITS = 512;

    // Bit position of the 32-bit word addressed by a byte offset; bits [1:0] are ignored.
    function automatic logic [31:0] word_lsb(input logic [31:0] off);
        return (off >> 2) << 5;
    endfunction

    // Tree walk from the root: node bit 0 leads to the left subtree. Sized for up to 8 ways.
    function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
        logic [2:0] idx;
        logic [2:0] way;
        idx = '0;
        way = '0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                way = {way[1:0], bits[idx]};
                idx = {idx[1:0], 1'b0} + 3'd1 + {2'b00, bits[idx]};
            end
        end
        return way;
    endfunction

    // Each node on the accessed way's path is pointed at the opposite subtree.
    function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] way,
                                               input int levels);
        logic [2:0] idx;
        logic [2:0] sh;
        logic [6:0] res;
        idx = '0;
        res = bits;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                sh       = way >> (levels - 1 - l);
                res[idx] = ~sh[0];
                idx      = {idx[1:0], 1'b0} + 3'd1 + {2'b00, sh[0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/l1_i_repl.sv
// rtl/l1_i_repl.sv - per-set replacement state; tree PLRU under L1_I_PLRU_EN, round-robin otherwise
module l1_i_repl
    import l1_i_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int INUM = DEF_INUM,
    localparam int WNUM = $clog2(WAYS),
    localparam int SETS = 1 << INUM
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            hit_i,
    input  logic            fill_i,
    input  logic [INUM-1:0] acc_set_i,
    input  logic [WNUM-1:0] acc_way_i,
    input  logic [INUM-1:0] vic_set_i,
    output logic [WNUM-1:0] vic_way_o
);

`ifdef L1_I_PLRU_EN
    logic [WAYS-2:0] plru_q [SETS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (hit_i || fill_i) begin
            plru_q[acc_set_i] <= (WAYS-1)'(plru_update(7'(plru_q[acc_set_i]), 3'(acc_way_i), WNUM));
        end
    end

    assign vic_way_o = WNUM'(plru_victim(7'(plru_q[vic_set_i]), WNUM));
`else
    logic [WNUM-1:0] ptr_q [SETS];
    logic            unused_acc;

    // Round-robin only advances on fills, so the hit way is irrelevant here.
    assign unused_acc = hit_i ^ (^acc_way_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (flush_i) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (fill_i) begin
            ptr_q[acc_set_i] <= ptr_q[acc_set_i] + 1'b1;
        end
    end

    assign vic_way_o = ptr_q[vic_set_i];
`endif

endmodule

// File: rtl/l1_i_nway_cache.sv
// rtl/l1_i_nway_cache.sv - N-way read-only L1 instruction cache top; L1_I_PLRU_EN selects tree PLRU
module l1_i_nway_cache
    import l1_i_pkg::*;
#(
    parameter int WAYS      = DEF_WAYS,
    parameter int INUM      = DEF_INUM,
    parameter int LINE_BITS = DEF_LINE_BITS,
    localparam int ONUM     = $clog2(LINE_BITS / 8),
    localparam int TNUM     = 32 - INUM - ONUM
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [TNUM-1:0]      tag_C_L1,
    input  logic [INUM-1:0]      index_C_L1,
    input  logic [ONUM-1:0]      offset,
    input  logic                 read_C_L1,
    input  logic                 flush,
    output logic                 stall,
    output logic [31:0]          read_data_L1_C,
    output logic                 read_valid_L1_C,
    output logic                 read_L1_L2,
    output logic [TNUM-1:0]      tag_L1_L2,
    output logic [INUM-1:0]      index_L1_L2,
    input  logic                 ready_L2_L1,
    input  logic [LINE_BITS-1:0] read_data_L2_L1
);

    localparam int WNUM  = $clog2(WAYS);
    localparam int SETS  = 1 << INUM;
    localparam int LSB_W = $clog2(LINE_BITS);

    state_e                  state_q;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [TNUM-1:0]         tag_q  [WAYS][SETS];
    logic [LINE_BITS-1:0]    data_q [WAYS][SETS];
    logic [TNUM-1:0]         tag_l2_q;
    logic [INUM-1:0]         idx_l2_q;
    logic [31:0]             rdata_q;
    logic                    rvalid_q;

    logic                    hit;
    logic [WNUM-1:0]         hit_way;
    logic [LINE_BITS-1:0]    hit_line;
    logic [LSB_W-1:0]        word_pos;
    logic [31:0]             hit_word;
    logic                    lookup, hit_en, miss_now, fill_en;
    logic [WNUM-1:0]         repl_vic, vic_way;
    logic [INUM-1:0]         acc_set;
    logic [WNUM-1:0]         acc_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[index_C_L1][w] && tag_q[w][index_C_L1] == tag_C_L1) begin
                hit     = 1'b1;
                hit_way = WNUM'(w);
            end
        end
    end

    assign hit_line = data_q[hit_way][index_C_L1];
    assign word_pos = LSB_W'(word_lsb(32'(offset)));
    assign hit_word = hit_line[word_pos +: 32];

    assign lookup   = (state_q == S_IDLE) && read_C_L1;
    assign hit_en   = lookup && hit;
    assign miss_now = lookup && !hit;
    assign fill_en  = (state_q == S_MISS) && ready_L2_L1 && !flush;

    // Invalid ways are filled lowest-first before the policy is consulted.
    always_comb begin
        vic_way = repl_vic;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_l2_q][w]) vic_way = WNUM'(w);
        end
    end

    assign acc_set = hit_en ? index_C_L1 : idx_l2_q;
    assign acc_way = hit_en ? hit_way : vic_way;

    l1_i_repl #(
        .WAYS (WAYS),
        .INUM (INUM)
    ) u_repl (
        .clk_i     (clk),
        .rst_ni    (nrst),
        .flush_i   (flush),
        .hit_i     (hit_en),
        .fill_i    (fill_en),
        .acc_set_i (acc_set),
        .acc_way_i (acc_way),
        .vic_set_i (idx_l2_q),
        .vic_way_o (repl_vic)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            tag_l2_q <= '0;
            idx_l2_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= hit_en;
            if (hit_en) rdata_q <= hit_word;
            if (flush) begin
                valid_q <= '0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (miss_now) begin
                        tag_l2_q <= tag_C_L1;
                        idx_l2_q <= index_C_L1;
                        state_q  <= S_MISS;
                    end
                    S_MISS: if (ready_L2_L1) begin
                        valid_q[idx_l2_q][vic_way] <= 1'b1;
                        state_q                    <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Line storage carries no reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[vic_way][idx_l2_q] <= read_data_L2_L1;
            tag_q[vic_way][idx_l2_q]  <= tag_l2_q;
        end
    end

    assign stall           = miss_now || (state_q == S_MISS);
    assign read_L1_L2      = (state_q == S_MISS);
    assign tag_L1_L2       = tag_l2_q;
    assign index_L1_L2     = idx_l2_q;
    assign read_data_L1_C  = rdata_q;
    assign read_valid_L1_C = rvalid_q;

endmodule

// File: tb/tb_l1_i_nway_cache.sv
// tb/tb_l1_i_nway_cache.sv - directed self-checking bench for l1_i_nway_cache (WAYS=4, INUM=5, 512-bit lines)
module tb_l1_i_nway_cache;

    logic         clk = 1'b0;
    logic         nrst;
    logic [20:0]  tag_C_L1;
    logic [4:0]   index_C_L1;
    logic [5:0]   offset;
    logic         read_C_L1;
    logic         flush;
    logic         stall;
    logic [31:0]  read_data_L1_C;
    logic         read_valid_L1_C;
    logic         read_L1_L2;
    logic [20:0]  tag_L1_L2;
    logic [4:0]   index_L1_L2;
    logic         ready_L2_L1;
    logic [511:0] read_data_L2_L1;

    int checks   = 0;
    int failures = 0;

    l1_i_nway_cache #(
        .WAYS      (4),
        .INUM      (5),
        .LINE_BITS (512)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .tag_C_L1        (tag_C_L1),
        .index_C_L1      (index_C_L1),
        .offset          (offset),
        .read_C_L1       (read_C_L1),
        .flush           (flush),
        .stall           (stall),
        .read_data_L1_C  (read_data_L1_C),
        .read_valid_L1_C (read_valid_L1_C),
        .read_L1_L2      (read_L1_L2),
        .tag_L1_L2       (tag_L1_L2),
        .index_L1_L2     (index_L1_L2),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mkline(input logic [20:0] t, input logic [4:0] ix);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = {t[11:0], ix[3:0], 12'h000, 4'(k)};
        return l;
    endfunction

    task automatic miss_fill(input string nm, input logic [20:0] t, input logic [4:0] ix,
                             input logic [5:0] off, input logic [511:0] line, input int lat);
        int st_n;
        int rl_n;
        logic [31:0] ew;
        ew = line[int'(off[5:2])*32 +: 32];
        tag_C_L1 = t; index_C_L1 = ix; offset = off; read_C_L1 = 1'b1;
        #1;
        st_n = stall ? 1 : 0;
        rl_n = read_L1_L2 ? 1 : 0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == lat) begin
                ready_L2_L1 = 1'b1;
                read_data_L2_L1 = line;
            end
            #1;
            if (stall) st_n++;
            if (read_L1_L2) rl_n++;
            if (k == 1) begin
                chk({nm, "_tag_l2"}, 32'(tag_L1_L2), 32'(t));
                chk({nm, "_idx_l2"}, 32'(index_L1_L2), 32'(ix));
            end
        end
        tick();
        ready_L2_L1 = 1'b0;
        #1;
        chk({nm, "_relookup_stall"}, 32'(stall), 32'd0);
        chk({nm, "_stall_cycles"}, 32'(st_n), 32'(lat + 1));
        chk({nm, "_req_cycles"}, 32'(rl_n), 32'(lat));
        tick();
        chk({nm, "_valid"}, 32'(read_valid_L1_C), 32'd1);
        chk({nm, "_data"}, read_data_L1_C, ew);
        read_C_L1 = 1'b0;
    endtask

    task automatic hit(input string nm, input logic [20:0] t, input logic [4:0] ix,
                       input logic [5:0] off, input logic [31:0] ew);
        tag_C_L1 = t; index_C_L1 = ix; offset = off; read_C_L1 = 1'b1;
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        tick();
        chk({nm, "_valid"}, 32'(read_valid_L1_C), 32'd1);
        chk({nm, "_data"}, read_data_L1_C, ew);
        read_C_L1 = 1'b0;
    endtask

    // Looks up without letting a miss start: the request is withdrawn before the edge.
    task automatic probe(input string nm, input logic [20:0] t, input logic [4:0] ix,
                         input logic exp_miss);
        tag_C_L1 = t; index_C_L1 = ix; offset = '0; read_C_L1 = 1'b1;
        #1;
        chk(nm, 32'(stall), 32'(exp_miss));
        read_C_L1 = 1'b0;
        tick();
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_rdata"}, read_data_L1_C, 32'd0);
        chk({nm, "_rvalid"}, 32'(read_valid_L1_C), 32'd0);
        chk({nm, "_req"}, 32'(read_L1_L2), 32'd0);
        chk({nm, "_tag_l2"}, 32'(tag_L1_L2), 32'd0);
        chk({nm, "_idx_l2"}, 32'(index_L1_L2), 32'd0);
    endtask

    initial begin
        logic [511:0] line0;
        logic [511:0] lw;
        logic [31:0]  w0;
        logic [20:0]  evict_tag;
        logic [20:0]  keep_tag;

        nrst = 1'b0; tag_C_L1 = '0; index_C_L1 = '0; offset = '0; read_C_L1 = 1'b0;
        flush = 1'b0; ready_L2_L1 = 1'b0; read_data_L2_L1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        nrst = 1'b1;
        tick();

        // Cold miss at 0x40: index 1, tag 0, L2 answers 4 cycles after the request edge.
        line0 = '0;
        line0[63:32] = 32'hDEADBEEF;
        miss_fill("cold", 21'd0, 5'd1, 6'd0, line0, 4);
        hit("cold_w1", 21'd0, 5'd1, 6'd4, 32'hDEADBEEF);
        tick();
        chk("strobe_one_cycle", 32'(read_valid_L1_C), 32'd0);

        for (int t = 1; t <= 4; t++) miss_fill("fill", 21'(t), 5'd2, 6'(t * 4), mkline(21'(t), 5'd2), 1);

        // Back-to-back hits, one accepted per cycle.
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                tag_C_L1 = 21'(i + 1); index_C_L1 = 5'd2; offset = '0; read_C_L1 = 1'b1;
            end else begin
                read_C_L1 = 1'b0;
            end
            #1;
            if (i < 4) chk("b2b_stall", 32'(stall), 32'd0);
            if (i > 0) begin
                lw = mkline(21'(i), 5'd2);
                w0 = lw[31:0];
                chk("b2b_valid", 32'(read_valid_L1_C), 32'd1);
                chk("b2b_data", read_data_L1_C, w0);
            end
            tick();
        end

        lw = mkline(21'd1, 5'd2);
        hit("hit_way0", 21'd1, 5'd2, 6'd0, lw[31:0]);
        lw = mkline(21'd3, 5'd2);
        hit("hit_way2", 21'd3, 5'd2, 6'd0, lw[31:0]);
        miss_fill("repl", 21'd5, 5'd2, 6'd0, mkline(21'd5, 5'd2), 2);
`ifdef L1_I_PLRU_EN
        evict_tag = 21'd2;
        keep_tag  = 21'd1;
`else
        evict_tag = 21'd1;
        keep_tag  = 21'd2;
`endif
        probe("repl_evicted_misses", evict_tag, 5'd2, 1'b1);
        probe("repl_kept_hits", keep_tag, 5'd2, 1'b0);
        probe("repl_way2_hits", 21'd3, 5'd2, 1'b0);
        probe("repl_way3_hits", 21'd4, 5'd2, 1'b0);
        probe("repl_new_hits", 21'd5, 5'd2, 1'b0);

        // Flush in the second MISS cycle, L2 answers the cycle after.
        tag_C_L1 = 21'd6; index_C_L1 = 5'd2; offset = '0; read_C_L1 = 1'b1;
        #1;
        chk("flush_miss_stall", 32'(stall), 32'd1);
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flush_req_before", 32'(read_L1_L2), 32'd1);
        tick();
        flush = 1'b0;
        read_C_L1 = 1'b0;
        ready_L2_L1 = 1'b1;
        read_data_L2_L1 = mkline(21'd6, 5'd2);
        #1;
        chk("flush_req_drop", 32'(read_L1_L2), 32'd0);
        chk("flush_stall_drop", 32'(stall), 32'd0);
        tick();
        ready_L2_L1 = 1'b0;
        probe("flush_ready_ignored", 21'd6, 5'd2, 1'b1);
        probe("flush_cold_gone", 21'd0, 5'd1, 1'b1);
        probe("flush_way2_gone", 21'd3, 5'd2, 1'b1);
        probe("flush_new_gone", 21'd5, 5'd2, 1'b1);

        // Asynchronous reset while a refill is outstanding.
        miss_fill("pre_rst", 21'd7, 5'd3, 6'd8, mkline(21'd7, 5'd3), 2);
        tag_C_L1 = 21'd8; index_C_L1 = 5'd3; offset = '0; read_C_L1 = 1'b1;
        tick();
        chk("rst_in_miss_req", 32'(read_L1_L2), 32'd1);
        chk("rst_in_miss_tag", 32'(tag_L1_L2), 32'd8);
        nrst = 1'b0;
        read_C_L1 = 1'b0;
        #1;
        chk_idle_outputs("rst_async");
        tick();
        nrst = 1'b1;
        tick();
        probe("rst_line_gone", 21'd7, 5'd3, 1'b1);

        // Ready pulse with no refill outstanding.
        miss_fill("pre_sp", 21'd9, 5'd4, 6'd12, mkline(21'd9, 5'd4), 3);
        ready_L2_L1 = 1'b1;
        read_data_L2_L1 = mkline(21'd10, 5'd4);
        #1;
        chk("spur_no_req", 32'(read_L1_L2), 32'd0);
        tick();
        ready_L2_L1 = 1'b0;
        probe("spur_no_fill", 21'd10, 5'd4, 1'b1);
        probe("spur_old_hits", 21'd9, 5'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_i_nway_cache.md
# l1_i_nway_cache

Parametrised N-way set-associative L1 instruction cache, read-only, sitting between the core fetch port and L2. Generalises the existing 2-way L1_I to configurable ways, sets and line width. Adds tree pseudo-LRU replacement, a registered data-valid strobe, and flush that aborts an in-flight refill. It keeps the same core/L2 handshake: the core holds its address while `stall` is high, and L2 answers with a one-cycle `ready_L2_L1` plus a full line.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- INUM, 5, index bits (2^INUM sets)
- LINE_BITS, 512, line width in bits; power of two, at least 64
- ONUM, $clog2(LINE_BITS/8), byte-offset bits (derived)
- TNUM, 32-INUM-ONUM, tag bits (derived)
- clk  in  1  single clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- tag_C_L1  in  TNUM  request tag, addr[31-:TNUM]
- index_C_L1  in  INUM  request index
- offset  in  ONUM  byte offset; [ONUM-1:2] selects the 32-bit word, [1:0] ignored
- read_C_L1  in  1  fetch request, level
- flush  in  1  invalidate all lines
- stall  out  1  core must hold request
- read_data_L1_C  out  32  fetched word, registered
- read_valid_L1_C  out  1  one-cycle strobe, read_data_L1_C valid
- read_L1_L2  out  1  line request to L2, level until ready
- tag_L1_L2  out  TNUM  captured miss tag
- index_L1_L2  out  INUM  captured miss index
- ready_L2_L1  in  1  one-cycle line return
- read_data_L2_L1  in  LINE_BITS  returned line, valid with ready_L2_L1

## Operation
- Storage
  - Per way and set: valid bit (flops), TNUM tag, LINE_BITS data.
  - Per set: replacement state.
- FSM states: IDLE, MISS.
- IDLE, read_C_L1=1: combinational compare of all ways against tag_C_L1/index_C_L1.
  - Hit: at the next edge, read_data_L1_C takes the selected word, read_valid_L1_C=1, and the replacement state is updated for the hit way. stall=0.
  - Miss: stall=1 combinationally in the same cycle. At the edge, capture tag/index into tag_L1_L2/index_L1_L2 and go to MISS.
- MISS
  - read_L1_L2=1 and stall=1.
  - On ready_L2_L1=1 at an edge:
    - Write the line into the victim way.
    - Set its valid bit and update replacement state (victim counts as accessed).
    - Go to IDLE.
  - The next IDLE cycle re-looks-up and hits.
- Victim selection
  - The lowest-index invalid way is always chosen first.
  - Otherwise the way given by the replacement policy (see Configuration).
- flush=1 at an edge, in any state:
  - Clear every valid bit and all replacement state.
  - Force IDLE; read_L1_L2 drops the next cycle.
  - A ready_L2_L1 in the same cycle is discarded. Flush wins.
- ready_L2_L1 while IDLE is ignored.
- Request fields may change while stall=1. The refill always uses the captured tag/index.
- read_C_L1=0 in IDLE: no lookup, no state change, read_valid_L1_C=0.

## Timing
- Reset values:
  - state IDLE, all valid=0, replacement state=0.
  - stall=0, read_data_L1_C=0, read_valid_L1_C=0, read_L1_L2=0, tag_L1_L2=0, index_L1_L2=0.
- Reset mid-MISS returns to IDLE asynchronously. All lines are invalid afterwards.
- Hit latency: 1 cycle from request to read_valid_L1_C, with one hit accepted per cycle.
- Miss latency: L2 latency (request edge to ready) + 2 cycles to read_valid_L1_C.
- stall is high from the miss cycle through the ready cycle inclusive.

## Configuration
- L1_I_PLRU_EN defined: tree pseudo-LRU with WAYS-1 bits per set.
  - Each node bit points toward the victim subtree (0 = left).
  - On access, the bits along the path are set to point away from the accessed way.
- L1_I_PLRU_EN undefined: per-set round-robin pointer of $clog2(WAYS) bits.
  - Advances by one on each fill only; hits do not change it.

## Structure
- Package l1_i_pkg holds:
  - the state enum;
  - default parameter constants;
  - word-select and PLRU update/victim functions.
- Sub-module l1_i_repl holds the per-set replacement array. It has an access port (set, way) and a victim lookup (set). Both policies live inside it under the macro.

## Test plan
All scenarios use WAYS=4, INUM=5, LINE_BITS=512.
- Cold miss:
  - Stimulus: read 0x0000_0040; L2 returns the line 4 cycles later with word1=0xDEADBEEF.
  - Response: stall high for 5 cycles. read_L1_L2 high for 4 cycles with index_L1_L2=1, tag_L1_L2=0. Then read_data_L1_C=0x0 (word0) with a strobe.
- Fill ways:
  - Stimulus: 4 distinct tags at index 2, then re-read all 4.
  - Response: no stall, data with a 1-cycle strobe per read.
- Replacement:
  - Stimulus: fill ways 0-3 at index 2, hit way0, hit way2, then miss at index 2.
  - Response with macro: victim way1.
  - Response without macro: victim way0.
- Flush mid-miss:
  - Stimulus: flush in the second MISS cycle, then ready_L2_L1 one cycle later.
  - Response: read_L1_L2=0 and stall=0 next cycle, the ready is ignored, and all previously filled addresses miss.
- Reset mid-refill:
  - Stimulus: drop nrst during MISS.
  - Response: all outputs 0 immediately; an address that hit before the reset misses afterwards.
- Spurious ready:
  - Stimulus: ready_L2_L1 pulse in IDLE with read_C_L1=0.
  - Response: no valid bits change, and the next read misses.
